pll_seq_ctrl: RTL and testbench
===============================

# pll_seq_ctrl

Bring-up and supervision sequencer for the system PLL (12 MHz reference in, 48 MHz CLKOP out). The block runs in the reference-clock domain, so it keeps working while the PLL output is absent or unstable. It drives the PLL RST and STDBY pins and samples the PLL LOCK output. It releases the downstream LCD/SPI domain reset only after lock has stayed stable, and it re-sequences the PLL on loss of lock, on a standby exit, or on a fault-clear request.

## Interface
- RST_CYCLES, 16: number of cycles pll_rst is held high per sequencing attempt (≥2)
- LOCK_TIMEOUT, 4096: cycles allowed in WAIT_LOCK before the attempt fails (≥4)
- STABLE_CYCLES, 256: consecutive cycles synced lock must stay high before release (≥2)
- MAX_RETRY, 3: failed attempts allowed before FAULT (1..15)

- clk  in  1  12 MHz reference clock, same net as the PLL CLKI
- rst_n  in  1  synchronous active-low reset
- pll_lock  in  1  PLL LOCK, asynchronous to clk
- stdby_req  in  1  level; high requests PLL standby
- fault_clr  in  1  single-cycle pulse; honoured only in FAULT
- pll_rst  out  1  to PLL RST, active high
- pll_stdby  out  1  to PLL STDBY
- pll_ready  out  1  PLL locked and stable
- dom_rst_n  out  1  active-low reset for the CLKOP domain
- fault  out  1  retry budget exhausted (sticky)
- retry_cnt  out  4  failed attempts in the current bring-up
- loss_cnt  out  8  lock-loss events in RUN, saturating at 255

## Operation
- pll_lock passes through a 2-flop synchronizer; lock_s is its output. All decisions use lock_s.
- A single cycle counter `cnt` is used, sized to the largest parameter. It clears on every state change.
- Reset values: state=HOLD, pll_rst=1, pll_stdby=0, pll_ready=0, dom_rst_n=0, fault=0, retry_cnt=0, loss_cnt=0, cnt=0, sync flops=0.
- All outputs are registered, decoded from the next state.
- States:
  - HOLD: pll_rst=1. When cnt==RST_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK: pll_rst=0.
    - lock_s=1 → STABLE.
    - Else if cnt==LOCK_TIMEOUT-1: if retry_cnt==MAX_RETRY-1, retry_cnt+1 → FAULT; otherwise retry_cnt+1 → HOLD.
  - STABLE: if lock_s=0 → WAIT_LOCK (fresh timeout; retry_cnt unchanged). If cnt==STABLE_CYCLES-1 with lock_s=1 → RUN.
  - RUN: pll_ready=1, dom_rst_n=1, retry_cnt cleared on entry.
    - stdby_req=1 → STANDBY.
    - Else if lock_s=0: loss_cnt+1 (saturating) → HOLD.
  - STANDBY: pll_stdby=1, pll_rst=0, pll_ready=0, dom_rst_n=0. When stdby_req=0 → HOLD (full re-sequence).
  - FAULT: pll_rst=1, fault=1, pll_ready=0, dom_rst_n=0. fault_clr=1 → HOLD with retry_cnt=0 and fault=0. fault_clr is ignored in every other state.
- Simultaneous stdby_req=1 and lock_s=0 in RUN: STANDBY wins and loss_cnt is not incremented.
- stdby_req is sampled only in RUN and STANDBY. A request during bring-up waits until RUN.
- dom_rst_n and pll_ready are always equal. The downstream domain is responsible for synchronizing dom_rst_n into CLKOP.
- rst_n low in any state returns everything to the reset values on the next edge, including fault and loss_cnt.

## Timing
- Edge 0 is the first rising edge with rst_n sampled high. pll_rst is high through edge RST_CYCLES-1 and low from edge RST_CYCLES.
- lock_s lags pll_lock by 2 edges.
- If lock_s is already high on entering WAIT_LOCK, STABLE is entered 1 edge later. Best-case pll_ready rise is edge RST_CYCLES+1+STABLE_CYCLES.
- From pll_lock falling in RUN to pll_ready/dom_rst_n falling: 3 edges (2 sync + 1 registered state). pll_rst rises on the same edge.
- Standby entry: pll_stdby rises, and pll_ready falls, 1 edge after stdby_req is sampled high in RUN.
- Standby exit: pll_stdby falls, and pll_rst rises, 1 edge after stdby_req is sampled low.
- Each timed-out attempt costs RST_CYCLES+LOCK_TIMEOUT cycles.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRY=2.
- Clean bring-up, pll_lock tied high → pll_rst low from edge 4; pll_ready and dom_rst_n rise at edge 13; retry_cnt=0.
- pll_lock never asserts → two attempts of 36 cycles each; retry_cnt reads 1, then 2; fault=1 after the second timeout with pll_rst=1. A fault_clr pulse → HOLD with retry_cnt=0; then a lock → RUN.
- Lock glitch: pll_lock low for 1 cycle during STABLE → back to WAIT_LOCK. pll_ready rises only after 8 further stable cycles; no retry is counted.
- Lock loss in RUN: drop pll_lock → pll_ready=0 and pll_rst=1 three edges later; loss_cnt=1. Re-lock → RUN again. Repeat 300 times → loss_cnt=255 (saturated).
- stdby_req raised in RUN in the same cycle lock_s falls → STANDBY, pll_stdby=1, loss_cnt unchanged. Lower stdby_req → pll_stdby=0, pll_rst=1 next edge, full re-sequence.
- rst_n pulsed low for 1 cycle during STABLE and during FAULT → all outputs at reset values on the next edge; fault and loss_cnt are cleared.

Source files
------------

// File: rtl/pll_seq_ctrl.sv
// PLL bring-up/supervision sequencer in the reference-clock domain: reset, lock wait, stability check, run, standby, fault.
// Latency: outputs registered from next state; pll_lock reaches decisions after a 2-flop sync (lock loss to pll_ready low: 3 edges).
// Backpressure: none; stdby_req is a level sampled in RUN/STANDBY, fault_clr is a pulse honoured only in FAULT.
module pll_seq_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRY     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       stdby_req,
  input  logic       fault_clr,
  output logic       pll_rst,
  output logic       pll_stdby,
  output logic       pll_ready,
  output logic       dom_rst_n,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_P = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_STDBY  = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          sync1_q, sync2_q;
  logic          lock_s;
  logic          rst_q, stdby_q, ready_q, fault_q;

  assign lock_s = sync2_q;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_lock;
      sync2_q <= sync1_q;
    end
  end

  // Next-state, counters and retry/loss bookkeeping.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    unique case (state_q)
      S_HOLD: begin
        if (cnt_q == CW'(RST_CYCLES - 1)) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lock_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          retry_d = retry_q + 4'd1;
          state_d = (retry_q == 4'(MAX_RETRY - 1)) ? S_FAULT : S_HOLD;
        end
      end
      S_STABLE: begin
        // A single low sample restarts the lock wait with a fresh timeout.
        if (!lock_s) state_d = S_WAIT;
        else if (cnt_q == CW'(STABLE_CYCLES - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        // Standby takes priority; a lock drop caused by entering standby is not a loss.
        if (stdby_req) begin
          state_d = S_STDBY;
        end else if (!lock_s) begin
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          state_d = S_HOLD;
        end
      end
      S_STDBY: begin
        if (!stdby_req) state_d = S_HOLD;
      end
      S_FAULT: begin
        if (fault_clr) begin
          state_d = S_HOLD;
          retry_d = 4'd0;
        end
      end
      default: state_d = S_HOLD;
    endcase
    // A successful bring-up forgives earlier failed attempts.
    if (state_d == S_RUN && state_q != S_RUN) retry_d = 4'd0;
    // Counter restarts on every state change; wrap in untimed states is harmless.
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
  end

  // State register plus outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      retry_q <= 4'd0;
      loss_q  <= 8'd0;
      rst_q   <= 1'b1;
      stdby_q <= 1'b0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
      rst_q   <= (state_d == S_HOLD) || (state_d == S_FAULT);
      stdby_q <= (state_d == S_STDBY);
      ready_q <= (state_d == S_RUN);
      fault_q <= (state_d == S_FAULT);
    end
  end

  assign pll_rst   = rst_q;
  assign pll_stdby = stdby_q;
  assign pll_ready = ready_q;
  assign dom_rst_n = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Directed bench for pll_seq_ctrl: expectations are queued with a target cycle, a monitor compares on the falling edge.
// Latency: n/a.
// Backpressure: n/a.
module tb_pll_seq_ctrl;

  localparam int R = 4;
  localparam int T = 32;
  localparam int S = 8;
  localparam int M = 2;

  logic       clk = 1'b0;
  logic       rst_n, pll_lock, stdby_req, fault_clr;
  logic       pll_rst, pll_stdby, pll_ready, dom_rst_n, fault;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  always #5 clk = ~clk;

  pll_seq_ctrl #(
    .RST_CYCLES(R), .LOCK_TIMEOUT(T), .STABLE_CYCLES(S), .MAX_RETRY(M)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .stdby_req(stdby_req),
    .fault_clr(fault_clr), .pll_rst(pll_rst), .pll_stdby(pll_stdby),
    .pll_ready(pll_ready), .dom_rst_n(dom_rst_n), .fault(fault),
    .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
  );

  typedef struct {
    int          at;
    string       name;
    logic [16:0] v;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [16:0] act;
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Queue an expectation d edges from now: {rst, stdby, ready, dom_rst_n, fault, retry, loss}.
  task automatic exp_out(input int d, input string nm, input logic r, input logic sb,
                         input logic rd, input logic f, input logic [3:0] rt,
                         input logic [7:0] ls);
    exp_t e;
    e.at   = cyc + d;
    e.name = nm;
    e.v    = {r, sb, rd, rd, f, rt, ls};
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drop lock in RUN, expect loss within 3 edges, relock, expect RUN 16 edges after the drop.
  task automatic loss_relock(input logic [7:0] lin, input logic [7:0] lout);
    pll_lock = 1'b0;
    exp_out(2, "loss_pre", 0, 0, 1, 0, 4'd0, lin);
    exp_out(3, "loss_drop", 1, 0, 0, 0, 4'd0, lout);
    tick(3);
    pll_lock = 1'b1;
    exp_out(12, "relock_wait", 0, 0, 0, 0, 4'd0, lout);
    exp_out(13, "relock_run", 0, 0, 1, 0, 4'd0, lout);
    tick(13);
  endtask

  // Two timed-out attempts from a fresh HOLD with lock absent, ending in FAULT.
  task automatic run_timeouts();
    exp_out(35, "to1_wait", 0, 0, 0, 0, 4'd0, 8'd0);
    exp_out(36, "to1_retry", 1, 0, 0, 0, 4'd1, 8'd0);
    exp_out(39, "to2_hold", 1, 0, 0, 0, 4'd1, 8'd0);
    exp_out(40, "to2_wait", 0, 0, 0, 0, 4'd1, 8'd0);
    exp_out(71, "to2_last", 0, 0, 0, 0, 4'd1, 8'd0);
    exp_out(72, "fault_set", 1, 0, 0, 1, 4'd2, 8'd0);
    tick(72);
  endtask

  // Compare every due expectation against the DUT outputs, away from the rising edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      mon_e = q.pop_front();
      act = {pll_rst, pll_stdby, pll_ready, dom_rst_n, fault, retry_cnt, loss_cnt};
      checks++;
      if (mon_e.at != cyc || act !== mon_e.v) begin
        failures++;
        $display("FAIL %s cyc=%0d: got rst=%b stdby=%b ready=%b dom_rst_n=%b fault=%b retry=%0d loss=%0d, required rst=%b stdby=%b ready=%b dom_rst_n=%b fault=%b retry=%0d loss=%0d",
                 mon_e.name, cyc, act[16], act[15], act[14], act[13], act[12], act[11:8], act[7:0],
                 mon_e.v[16], mon_e.v[15], mon_e.v[14], mon_e.v[13], mon_e.v[12],
                 mon_e.v[11:8], mon_e.v[7:0]);
      end
    end
  end

  logic [7:0] l_cur, l_nxt;

  initial begin
    rst_n = 1'b0; pll_lock = 1'b0; stdby_req = 1'b0; fault_clr = 1'b0;
    tick(3);
    exp_out(0, "reset_vals", 1, 0, 0, 0, 4'd0, 8'd0);

    // Clean bring-up with lock tied high.
    rst_n = 1'b1; pll_lock = 1'b1;
    exp_out(3, "boot_hold_last", 1, 0, 0, 0, 4'd0, 8'd0);
    exp_out(4, "boot_rst_low", 0, 0, 0, 0, 4'd0, 8'd0);
    exp_out(12, "boot_not_ready", 0, 0, 0, 0, 4'd0, 8'd0);
    exp_out(13, "boot_ready", 0, 0, 1, 0, 4'd0, 8'd0);
    tick(13);

    // One lock loss in RUN, then relock.
    loss_relock(8'd0, 8'd1);

    // Standby request arriving in the same cycle lock_s falls.
    pll_lock = 1'b0;
    exp_out(2, "sb_pre", 0, 0, 1, 0, 4'd0, 8'd1);
    tick(2);
    stdby_req = 1'b1;
    exp_out(1, "sb_enter", 0, 1, 0, 0, 4'd0, 8'd1);
    tick(1);
    pll_lock = 1'b1;
    exp_out(3, "sb_hold", 0, 1, 0, 0, 4'd0, 8'd1);
    tick(3);
    stdby_req = 1'b0;
    exp_out(1, "sb_exit", 1, 0, 0, 0, 4'd0, 8'd1);
    exp_out(13, "sb_reseq_wait", 0, 0, 0, 0, 4'd0, 8'd1);
    exp_out(14, "sb_reseq_run", 0, 0, 1, 0, 4'd0, 8'd1);
    tick(14);

    // Repeated lock loss until loss_cnt saturates.
    l_cur = 8'd1;
    for (int i = 0; i < 300; i++) begin
      l_nxt = (l_cur == 8'd255) ? 8'd255 : l_cur + 8'd1;
      loss_relock(l_cur, l_nxt);
      l_cur = l_nxt;
    end

    // One-cycle lock glitch while in STABLE.
    pll_lock = 1'b0;
    tick(3);
    pll_lock = 1'b1;
    tick(7);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    exp_out(5, "glitch_no_early", 0, 0, 0, 0, 4'd0, 8'd255);
    exp_out(10, "glitch_not_ready", 0, 0, 0, 0, 4'd0, 8'd255);
    exp_out(11, "glitch_run", 0, 0, 1, 0, 4'd0, 8'd255);
    tick(11);

    // Reset pulse while in STABLE.
    pll_lock = 1'b0;
    tick(3);
    pll_lock = 1'b1;
    tick(6);
    exp_out(0, "pre_rst_loss", 0, 0, 0, 0, 4'd0, 8'd255);
    rst_n = 1'b0;
    exp_out(1, "rst_in_stable", 1, 0, 0, 0, 4'd0, 8'd0);
    tick(1);
    rst_n = 1'b1; pll_lock = 1'b0;

    // Timeouts into FAULT, then reset pulse in FAULT.
    run_timeouts();
    exp_out(8, "fault_sticky", 1, 0, 0, 1, 4'd2, 8'd0);
    tick(8);
    rst_n = 1'b0;
    exp_out(1, "rst_in_fault", 1, 0, 0, 0, 4'd0, 8'd0);
    tick(1);
    rst_n = 1'b1;

    // Timeouts into FAULT again, then fault_clr and lock.
    run_timeouts();
    tick(3);
    fault_clr = 1'b1;
    exp_out(1, "fclr_hold", 1, 0, 0, 0, 4'd0, 8'd0);
    tick(1);
    fault_clr = 1'b0; pll_lock = 1'b1;
    exp_out(4, "fclr_wait", 0, 0, 0, 0, 4'd0, 8'd0);
    exp_out(12, "fclr_not_ready", 0, 0, 0, 0, 4'd0, 8'd0);
    exp_out(13, "fclr_run", 0, 0, 1, 0, 4'd0, 8'd0);
    tick(13);

    // fault_clr outside FAULT has no effect.
    fault_clr = 1'b1;
    exp_out(1, "fclr_ignored_run", 0, 0, 1, 0, 4'd0, 8'd0);
    tick(1);
    fault_clr = 1'b0;

    // One timeout after a lock loss, then lock: retry_cnt clears on RUN entry.
    pll_lock = 1'b0;
    exp_out(3, "rt_loss", 1, 0, 0, 0, 4'd0, 8'd1);
    exp_out(39, "rt_timeout", 1, 0, 0, 0, 4'd1, 8'd1);
    tick(39);
    pll_lock = 1'b1;
    exp_out(12, "rt_not_ready", 0, 0, 0, 0, 4'd1, 8'd1);
    exp_out(13, "rt_run_clear", 0, 0, 1, 0, 4'd0, 8'd1);
    tick(13);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 50 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
